// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: arbiter state encoding and datapath widths.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REGADDR_W = 5;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_BUSY_IF  = 3'd1,
    ARB_BUSY_MEM = 3'd2,
    ARB_DONE_IF  = 3'd3,
    ARB_DONE_MEM = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that times the fixed memory latency; holds at zero.
module mem_lat_timer #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(MEM_LAT);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access,
// one access at a time, and raises the pipeline stalls while a request is pending.
module mem_port_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_ready,
  output logic            port_en,
  output logic            port_we,
  output logic [XLEN-1:0] port_addr,
  output logic [XLEN-1:0] port_wdata,
  input  logic [XLEN-1:0] port_rdata,
  output logic            stall_if,
  output logic            stall_mem
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic w_issue_if;
  logic w_issue_mem;
  logic w_cap_if;
  logic w_cap_mem;
  logic w_busy;
  logic w_cnt_zero;

  logic            r_port_en;
  logic            r_port_we;
  logic [XLEN-1:0] r_port_addr;
  logic [XLEN-1:0] r_port_wdata;
  logic [XLEN-1:0] r_if_rdata;
  logic [XLEN-1:0] r_mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // After a completion the other requester gets the next slot, so neither can starve.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (mem_req)     w_state_nxt = ARB_BUSY_MEM;
        else if (if_req) w_state_nxt = ARB_BUSY_IF;
      end
      ARB_BUSY_IF:  if (w_cnt_zero) w_state_nxt = ARB_DONE_IF;
      ARB_BUSY_MEM: if (w_cnt_zero) w_state_nxt = ARB_DONE_MEM;
      ARB_DONE_IF:  w_state_nxt = mem_req ? ARB_BUSY_MEM : ARB_IDLE;
      ARB_DONE_MEM: w_state_nxt = if_req  ? ARB_BUSY_IF  : ARB_IDLE;
      default:      w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_issue_if  = 1'b0;
    w_issue_mem = 1'b0;
    w_cap_if    = 1'b0;
    w_cap_mem   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_issue_mem = mem_req;
        w_issue_if  = ~mem_req & if_req;
      end
      ARB_BUSY_IF: begin
        w_busy   = 1'b1;
        w_cap_if = w_cnt_zero;
      end
      ARB_BUSY_MEM: begin
        w_busy    = 1'b1;
        w_cap_mem = w_cnt_zero;
      end
      ARB_DONE_IF:  w_issue_mem = mem_req;
      ARB_DONE_MEM: w_issue_if  = if_req;
      default: ;
    endcase
  end

  mem_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_issue_if | w_issue_mem),
    .i_dec  (w_busy),
    .o_zero (w_cnt_zero)
  );

  // Requester inputs are captured only on the issue edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port_en    <= 1'b0;
      r_port_we    <= 1'b0;
      r_port_addr  <= '0;
      r_port_wdata <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      r_port_en <= w_issue_if | w_issue_mem;
      r_port_we <= w_issue_mem & mem_we;
      if (w_issue_mem) begin
        r_port_addr  <= mem_addr;
        r_port_wdata <= mem_wdata;
      end else if (w_issue_if) begin
        r_port_addr  <= if_addr;
        r_port_wdata <= '0;
      end
      if (w_cap_if)  r_if_rdata  <= port_rdata;
      if (w_cap_mem) r_mem_rdata <= port_rdata;
    end
  end

  assign port_en    = r_port_en;
  assign port_we    = r_port_we;
  assign port_addr  = r_port_addr;
  assign port_wdata = r_port_wdata;
  assign if_rdata   = r_if_rdata;
  assign mem_rdata  = r_mem_rdata;
  assign if_ready   = (r_state == ARB_DONE_IF);
  assign mem_ready  = (r_state == ARB_DONE_MEM);
  assign stall_if   = if_req & ~if_ready;
  assign stall_mem  = mem_req & ~mem_ready;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared memory port of the 5-stage pipeline. It serves instruction fetch (IF stage) and data load/store (MEM stage, driven from the Ex/Mem pipeline register's memRead/memWrite/ALUOut/readData2 outputs). The shared memory has a fixed read/write latency. The block issues one access at a time, returns read data with a one-cycle ready pulse, and produces the stall signals that freeze the pipeline registers while an access is outstanding.

## Interface
- MEM_LAT, 2: cycles from port_en to valid port_rdata; legal range ≥1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  32  fetch address (Ex/Mem-independent PC)
- if_rdata  out  32  fetched instruction; valid only while if_ready=1
- if_ready  out  1  one-cycle pulse, fetch complete
- mem_req  in  1  data request (Mem_memRead | Mem_memWrite); held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  data address (Mem_ALUOut)
- mem_wdata  in  32  store data (Mem_readData2)
- mem_rdata  out  32  load data; valid only while mem_ready=1
- mem_ready  out  1  one-cycle pulse, load or store complete
- port_en  out  1  memory access strobe, exactly one cycle per access
- port_we  out  1  memory write enable, qualified by port_en
- port_addr  out  32  memory address
- port_wdata  out  32  memory write data
- port_rdata  in  32  memory read data, valid MEM_LAT cycles after port_en
- stall_if  out  1  freeze PC and IF/ID register
- stall_mem  out  1  freeze all pipeline registers up to and including Ex/Mem; bubble into Mem/WB

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
- Transitions from IDLE:
  - mem_req=1 → BUSY_MEM; MEM has priority because it carries the older instruction.
  - else if_req=1 → BUSY_IF.
  - else remain in IDLE.
- Issue edge (leaving IDLE or DONE_*):
  - Register port_addr and port_wdata from the selected requester.
  - port_we = mem_we for a MEM access, 0 for an IF access.
  - port_en = 1 for the next cycle only.
  - Load the latency counter with MEM_LAT.
- BUSY_*:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture port_rdata into if_rdata or mem_rdata and go to the matching DONE_* state.
  - Stores also wait the full MEM_LAT; the captured data for a store is don't-care.
- DONE_IF: assert if_ready. The next state is never a new IF access, because if_req is still high this cycle.
  - mem_req=1 → issue MEM, go to BUSY_MEM.
  - else → IDLE.
- DONE_MEM: assert mem_ready.
  - if_req=1 → issue IF, go to BUSY_IF.
  - else → IDLE.
  - This alternation guarantees IF cannot starve under back-to-back data accesses.
- Stall outputs (combinational from registered state):
  - stall_if = if_req & ~if_ready.
  - stall_mem = mem_req & ~mem_ready.
- Requester inputs are sampled only on the issue edge; changes while BUSY are ignored.
- Pipeline flush is handled by the requesters. A withdrawn request is still completed, and its ready pulse may be ignored.

## Timing
- Reset (rst=1 at a clock edge):
  - State goes to IDLE and the counter to 0.
  - port_en, port_we, if_ready and mem_ready go to 0.
  - port_addr, port_wdata, if_rdata and mem_rdata go to 32'b0.
  - An in-flight access is abandoned; its port_rdata is never captured and no ready pulse follows.
- Latency with the request seen in IDLE at cycle R:
  - port_en in cycle R+1.
  - Capture at the end of cycle R+1+MEM_LAT.
  - Ready in cycle R+2+MEM_LAT.
- Chained access: issue from DONE_* puts port_en in the cycle after the ready cycle.
- Counter width is $clog2(MEM_LAT+1); no wrap, it holds at 0 outside BUSY.
- Simultaneous if_req and mem_req in IDLE: MEM is served first, then IF from DONE_MEM.
- rst has priority over every other event, including a capture cycle.

## Structure
- Shared package pipe_ctrl_pkg:
  - arb_state_t enum (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_MEM, ARB_DONE_IF, ARB_DONE_MEM).
  - Constants XLEN=32 and REGADDR_W=5.
- One sub-module, mem_lat_timer: loadable down-counter with a zero flag, parameterised by MEM_LAT.

## Test plan
All scenarios use MEM_LAT=2.
- Single fetch: if_req=1, if_addr=0x40 at cycle 0 → port_en=1, port_addr=0x40, port_we=0 in cycle 1; port_rdata=0x00A00093 in cycle 3; if_ready=1, if_rdata=0x00A00093 in cycle 4; stall_if=1 in cycles 0–3.
- Store: mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF → port_we=1 with that address and data for one cycle; mem_ready pulses 3 cycles after port_en; stall_mem=1 until then.
- Contention: if_req and mem_req both rise in cycle 0 (load at 0x200) → MEM issued in cycle 1, mem_ready in cycle 4, IF issued in cycle 5, if_ready in cycle 8.
- Back-to-back loads with if_req held → accesses alternate MEM, IF, MEM; no two consecutive MEM issues while if_req=1.
- Reset mid-access: rst=1 in cycle 2 of a fetch → all outputs 0 in the next cycle, no if_ready ever; a new request after rst falls completes normally.
- MEM_LAT=1 build: single load → ready in cycle R+3.
